// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register sequencer.
//   seq_state_e : sequencer FSM states
//   CW_*        : bit positions inside the 16-bit engine control word
//   RSP_*       : completion codes reported on rsp_err
//   cw_pack()   : builds one engine control word
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StChk,
    StResp
  } seq_state_e;

  localparam int unsigned CW_RW    = 1;
  localparam int unsigned CW_START = 2;
  localparam int unsigned CW_ACK   = 3;
  localparam int unsigned CW_STOP  = 4;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_NACK    = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  // Bits not named here stay 0.
  function automatic logic [15:0] cw_pack(input logic [7:0] data, input logic start,
                                          input logic stop, input logic ack, input logic rw);
    logic [15:0] w;
    w           = '0;
    w[15:8]     = data;
    w[CW_START] = start;
    w[CW_STOP]  = stop;
    w[CW_ACK]   = ack;
    w[CW_RW]    = rw;
    return w;
  endfunction

endpackage

// File: rtl/i2c_sclk_gen.sv
// SCL reference and engine step-strobe generator.
//   clk, reset   : system clock, synchronous active-high reset
//   ctrl_sclk    : low for the first half of each CLK_DIV-cycle period, high for the second
//   ctrl_sclk_en : one-cycle pulse at count CLK_DIV/4 (middle of the low phase)
module i2c_sclk_gen
  import i2c_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 500
) (
  input  logic clk,
  input  logic reset,
  output logic ctrl_sclk,
  output logic ctrl_sclk_en
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2);
  localparam logic [CntW-1:0] CntQtr  = CntW'(CLK_DIV / 4);

  if (CLK_DIV < 8 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("CLK_DIV must be even and at least 8");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            en_q, en_d;

  // Outputs are registered from the next count so they line up with cnt_q.
  always_comb begin
    cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    sclk_d = (cnt_d >= CntHalf);
    en_d   = (cnt_d == CntQtr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      en_q   <= en_d;
    end
  end

  assign ctrl_sclk    = sclk_q;
  assign ctrl_sclk_en = en_q;

endmodule

// File: rtl/i2c_reg_seq.sv
// I2C register-transaction sequencer driving the trans_bit byte engine.
//   Host side  : cmd_valid/cmd_ready/cmd_rd/cmd_dev/cmd_reg/cmd_wdata in,
//                rsp_valid/rsp_rdata/rsp_err out (01 = NACK, 10 = timeout)
//   Engine side: ctrl_sclk, ctrl_sclk_en, st_trigger, wr_data_in, ack_err_clr out;
//                trans_done, busy_flag, ack_err, rd_data_out_en, rd_data_out in
// Write: START+addr/W, reg, data+STOP. Read: START+addr/W, reg, rSTART+addr/R, byte+NACK+STOP.
// Optional macro I2C_SEQ_TIMEOUT_EN adds a per-byte timeout of TIMEOUT_CYC cycles.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 500,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [6:0]  cmd_dev,
  input  logic [7:0]  cmd_reg,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        ctrl_sclk,
  output logic        ctrl_sclk_en,
  output logic        st_trigger,
  output logic [15:0] wr_data_in,
  output logic        ack_err_clr,
  input  logic        trans_done,
  input  logic        busy_flag,
  input  logic        ack_err,
  input  logic        rd_data_out_en,
  input  logic [7:0]  rd_data_out
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  i2c_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk          (clk),
    .reset        (reset),
    .ctrl_sclk    (ctrl_sclk),
    .ctrl_sclk_en (ctrl_sclk_en)
  );

  seq_state_e  state_q, state_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cw_q, cw_d;
  logic        trig_q, trig_d;
  logic        clr_q, clr_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_prev_q, done_prev_d;
  logic        seen_en_q, seen_en_d;
  logic [15:0] byte_word;
  logic        last_byte;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`endif

  // Control word for the current byte of the command.
  always_comb begin
    byte_word = '0;
    case (idx_q)
      2'd0:    byte_word = cw_pack({dev_q, 1'b0}, 1'b1, 1'b0, 1'b0, 1'b1);
      2'd1:    byte_word = cw_pack(reg_q, 1'b0, 1'b0, 1'b0, 1'b1);
      2'd2:    byte_word = rd_q ? cw_pack({dev_q, 1'b1}, 1'b1, 1'b0, 1'b0, 1'b1)
                                : cw_pack(wdata_q, 1'b0, 1'b1, 1'b0, 1'b1);
      default: byte_word = cw_pack(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endcase
    last_byte = rd_q ? (idx_q == 2'd3) : (idx_q == 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    cw_d        = cw_q;
    trig_d      = trig_q;
    clr_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    done_prev_d = trans_done;
    seen_en_d   = seen_en_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rd_d    = cmd_rd;
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          wdata_d = cmd_wdata;
          idx_d   = 2'd0;
          rdata_d = 8'h00;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cw_d      = byte_word;
        trig_d    = 1'b1;
        seen_en_d = 1'b0;
        state_d   = StIssue;
      end
      StIssue: begin
        // Engine has left idle/finish once it is busy with done low.
        if (busy_flag && !trans_done) begin
          trig_d  = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (rd_data_out_en) rdata_d = rd_data_out;
        if (trans_done && !done_prev_q) begin
          seen_en_d = 1'b0;
          state_d   = StChk;
        end
      end
      StChk: begin
        // ack_err is only trustworthy one cycle after the engine strobe.
        if (seen_en_q) begin
          if (cw_q[CW_RW] && ack_err) begin
            rsp_err_d   = RSP_NACK;
            clr_d       = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata_q;
            state_d     = StResp;
          end else if (last_byte) begin
            rsp_err_d   = RSP_OK;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata_q;
            state_d     = StResp;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StLoad;
          end
        end else if (ctrl_sclk_en) begin
          seen_en_d = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef I2C_SEQ_TIMEOUT_EN
    if (state_q == StLoad) begin
      tmo_d = '0;
    end else if (state_q == StIssue || state_q == StWait || state_q == StChk) begin
      if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
        trig_d      = 1'b0;
        clr_d       = 1'b1;
        rsp_err_d   = RSP_TIMEOUT;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdata_q;
        state_d     = StResp;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      cw_q        <= '0;
      trig_q      <= 1'b0;
      clr_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RSP_OK;
      rdata_q     <= '0;
      done_prev_q <= 1'b0;
      seen_en_q   <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      cw_q        <= cw_d;
      trig_q      <= trig_d;
      clr_q       <= clr_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      done_prev_q <= done_prev_d;
      seen_en_q   <= seen_en_d;
`ifdef I2C_SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign cmd_ready   = ready_q;
  assign st_trigger  = trig_q;
  assign wr_data_in  = cw_q;
  assign ack_err_clr = clr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
`ifdef I2C_SEQ_TIMEOUT_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = rsp_err_q & ~RSP_TIMEOUT;
`endif

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq with a behavioural trans_bit engine model.
// Expected engine words and responses are queued when a command is driven and
// compared when the engine accepts a byte or the sequencer pulses rsp_valid.
module tb_i2c_reg_seq;

  typedef struct packed {
    logic       chk_rdata;
    logic [7:0] rdata;
    logic [1:0] err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd = 1'b0;
  logic [6:0]  cmd_dev = '0;
  logic [7:0]  cmd_reg = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        ctrl_sclk;
  logic        ctrl_sclk_en;
  logic        st_trigger;
  logic [15:0] wr_data_in;
  logic        ack_err_clr;
  logic        trans_done = 1'b0;
  logic        busy_flag = 1'b0;
  logic        ack_err = 1'b0;
  logic        rd_data_out_en = 1'b0;
  logic [7:0]  rd_data_out = '0;

  int n_tests = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  int clr_cnt = 0;
  int word_cnt = 0;

  logic       nack_en = 1'b0;
  logic       stuck = 1'b0;
  logic [7:0] slave_rdata = 8'h00;

  logic [15:0] exp_words[$];
  rsp_t        exp_rsp[$];

  logic [15:0] e_word = '0;
  int          e_cnt = 0;

  i2c_reg_seq #(
    .CLK_DIV     (8),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rd         (cmd_rd),
    .cmd_dev        (cmd_dev),
    .cmd_reg        (cmd_reg),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .ctrl_sclk      (ctrl_sclk),
    .ctrl_sclk_en   (ctrl_sclk_en),
    .st_trigger     (st_trigger),
    .wr_data_in     (wr_data_in),
    .ack_err_clr    (ack_err_clr),
    .trans_done     (trans_done),
    .busy_flag      (busy_flag),
    .ack_err        (ack_err),
    .rd_data_out_en (rd_data_out_en),
    .rd_data_out    (rd_data_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word layout: [15:8] byte, [4] stop, [3] ack, [2] start, [1] rw.
  function automatic logic [15:0] mk(input logic [7:0] b, input logic stop, input logic ack,
                                     input logic start, input logic rw);
    return {b, 3'b000, stop, ack, start, rw, 1'b0};
  endfunction

  // Engine model: runs on the falling edge so DUT outputs are stable.
  always @(negedge clk) begin
    if (reset) begin
      busy_flag      <= 1'b0;
      trans_done     <= 1'b0;
      ack_err        <= 1'b0;
      rd_data_out_en <= 1'b0;
      e_cnt          <= 0;
    end else begin
      rd_data_out_en <= 1'b0;
      if (ack_err_clr) ack_err <= 1'b0;
      if (!busy_flag) begin
        if (st_trigger) begin
          word_cnt <= word_cnt + 1;
          if (exp_words.size() == 0) check_eq("word_extra", wr_data_in, 32'hdead);
          else check_eq("word", wr_data_in, exp_words.pop_front());
          e_word     <= wr_data_in;
          busy_flag  <= 1'b1;
          trans_done <= 1'b0;
          e_cnt      <= 0;
        end
      end else if (!stuck) begin
        e_cnt <= e_cnt + 1;
        if (e_cnt == 7 && !e_word[1]) begin
          rd_data_out_en <= 1'b1;
          rd_data_out    <= slave_rdata;
        end
        if (e_cnt == 9) begin
          busy_flag  <= 1'b0;
          trans_done <= 1'b1;
          if (nack_en && e_word[2] && e_word[1]) ack_err <= 1'b1;
        end
      end
    end
  end

  // Response scoreboard and pulse counters.
  always @(negedge clk) begin
    if (!reset && ack_err_clr) clr_cnt++;
    if (!reset && rsp_valid) begin
      rsp_t e;
      rsp_cnt++;
      if (exp_rsp.size() == 0) begin
        check_eq("rsp_extra", 32'(rsp_err), 32'hdead);
      end else begin
        e = exp_rsp.pop_front();
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.chk_rdata) check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic do_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input int nbytes, input logic [1:0] err,
                        input logic [7:0] rdata);
    logic [15:0] tbl[4];
    bit ok;
    tbl[0] = mk({dev, 1'b0}, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[1] = mk(rg, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[2] = rd ? mk({dev, 1'b1}, 1'b0, 1'b0, 1'b1, 1'b1) : mk(wd, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbytes; i++) exp_words.push_back(tbl[i]);
    exp_rsp.push_back('{chk_rdata: rd, rdata: rdata, err: err});
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("cmd_ready_wait", 32'd0, 32'd1);
    cmd_rd    = rd;
    cmd_dev   = dev;
    cmd_reg   = rg;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input int n0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_cnt > n0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    repeat (20) @(negedge clk);
    check_eq({tag, "_rsp_once"}, 32'(rsp_cnt), 32'(n0 + 1));
    check_eq({tag, "_bytes_left"}, 32'(exp_words.size()), 32'd0);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, "_sclk"}, 32'(ctrl_sclk), 32'd0);
    check_eq({tag, "_sclk_en"}, 32'(ctrl_sclk_en), 32'd0);
    check_eq({tag, "_trigger"}, 32'(st_trigger), 32'd0);
    check_eq({tag, "_word"}, 32'(wr_data_in), 32'd0);
    check_eq({tag, "_clr"}, 32'(ack_err_clr), 32'd0);
  endtask

  initial begin
    int  n0;
    int  c0;
    int  w0;
    int  low_idx;
    int  last_rise;
    bit  synced;
    bit  got;
    logic prev;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Divider: period 8, en exactly at third low-phase cycle.
    prev = 1'b0;
    low_idx = 0;
    last_rise = -1;
    synced = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (!ctrl_sclk && prev) begin
        low_idx = 0;
        synced = 1'b1;
      end else if (!ctrl_sclk) begin
        low_idx++;
      end
      if (ctrl_sclk && !prev) begin
        if (last_rise >= 0) check_eq("sclk_period", 32'(c - last_rise), 32'd8);
        last_rise = c;
      end
      if (synced) check_eq("sclk_en_phase", 32'(ctrl_sclk_en), 32'(!ctrl_sclk && low_idx == 2));
      prev = ctrl_sclk;
    end

    // Register write with ACKing slave.
    n0 = rsp_cnt;
    do_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 3, 2'b00, 8'h00);
    finish_cmd("wr", n0);

    // Register read, slave returns 0x3C.
    slave_rdata = 8'h3C;
    n0 = rsp_cnt;
    do_cmd(1'b1, 7'h50, 8'h02, 8'h00, 4, 2'b00, 8'h3C);
    finish_cmd("rd", n0);

    // Second read with a different pattern.
    slave_rdata = 8'hC3;
    n0 = rsp_cnt;
    do_cmd(1'b1, 7'h2B, 8'hFF, 8'h00, 4, 2'b00, 8'hC3);
    finish_cmd("rd2", n0);

    // Address NACK on a write: one byte, clear pulse, err 01.
    nack_en = 1'b1;
    n0 = rsp_cnt;
    c0 = clr_cnt;
    do_cmd(1'b0, 7'h33, 8'h44, 8'h55, 1, 2'b01, 8'h00);
    finish_cmd("nack_wr", n0);
    check_eq("nack_wr_clr", 32'(clr_cnt), 32'(c0 + 1));

    // Address NACK on a read aborts before the repeated START.
    n0 = rsp_cnt;
    c0 = clr_cnt;
    do_cmd(1'b1, 7'h12, 8'h34, 8'h00, 1, 2'b01, 8'h00);
    finish_cmd("nack_rd", n0);
    check_eq("nack_rd_clr", 32'(clr_cnt), 32'(c0 + 1));
    nack_en = 1'b0;

    // Reset while byte 1 of a write is in flight.
    w0 = word_cnt;
    do_cmd(1'b0, 7'h50, 8'h20, 8'h5A, 3, 2'b00, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (word_cnt >= w0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("midrst_b1_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    #1;
    exp_words.delete();
    exp_rsp.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    n0 = rsp_cnt;
    do_cmd(1'b0, 7'h50, 8'h20, 8'h5A, 3, 2'b00, 8'h00);
    finish_cmd("after_rst", n0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Engine never finishes: timeout 1000 cycles after the byte is issued.
    stuck = 1'b1;
    n0 = rsp_cnt;
    do_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1, 2'b10, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (st_trigger) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("tmo_trigger", 32'(got), 32'd1);
    c0 = 0;
    got = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      c0++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("tmo_seen", 32'(got), 32'd1);
    check_eq("tmo_latency", 32'(c0), 32'd1000);
    repeat (5) @(negedge clk);
    check_eq("tmo_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check_eq("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
